mtimer: RTL and testbench
=========================

# mtimer

Memory-mapped machine timer serving as the source of `timer_interrupt` for the 3-stage RISC-V core. It sits on the MEM-WB stage data bus next to `data_mem` and decodes the same load/store signals the core drives there. It holds a prescaled 64-bit `mtime` and a 64-bit `mtimecmp`, and raises a level interrupt while `mtime >= mtimecmp`.

## Interface
- `BASE_ADDR`, default 32'h0000_1000: region base; a 32-byte window, aligned to 32 bytes.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rd_en` in 1: load strobe from the MEM-WB stage.
- `wr_en` in 1: store strobe from the MEM-WB stage.
- `addr` in 32: byte address (ALU result).
- `mem_acc_mode` in 3: load/store funct3. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `wdata` in 32: store data (rs2 value).
- `hit` out 1: `addr` falls in the window. The core uses it to select `rdata` over `data_mem`.
- `rdata` out 32: combinational load data, already extended.
- `timer_interrupt` out 1: registered level interrupt to the CSR unit.

## Operation
- Word offsets, from `addr[4:2]`:
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 MTIMECMP_LO
  - 3 MTIMECMP_HI
  - 4 CTRL: bit0 `en`, bit1 `irq_en`, other bits read 0
  - 5 PRESCALE: bits[15:0], upper bits read 0
  - 6–7 reserved: read 0, writes ignored
- Reset values: mtime 0, mtimecmp 64'hFFFF_FFFF_FFFF_FFFF, CTRL 0, PRESCALE 0, prescale counter 0, `timer_interrupt` 0.
- `hit` = (`addr[31:5]` == `BASE_ADDR[31:5]`).
- Writes occur only when `wr_en && hit`.
- Lane rules:
  - B writes lane `addr[1:0]` with `wdata[7:0]`.
  - H writes lanes {`addr[1]`,0..1} with `wdata[15:0]`.
  - W writes all lanes with `wdata`.
  - Untouched bytes keep their value.
- Misaligned H (`addr[0]`=1) or W (`addr[1:0]`≠0) accesses are illegal: the write is dropped and the read returns 0.
- Reads: `rdata` = 0 unless `rd_en && hit`. Otherwise:
  - B and H sign-extend the selected lane.
  - BU and HU zero-extend it.
  - W returns the full word.
- Prescaler, when `en`=1:
  - Each cycle, `pcnt` increments.
  - When `pcnt == PRESCALE`, `pcnt` clears to 0 and `mtime` increments by 1 (a "tick").
  - PRESCALE=0 gives a tick every cycle; PRESCALE=N gives a tick every N+1 cycles.
- When `en`=0, `pcnt` and `mtime` hold.
- Writing CTRL or PRESCALE clears `pcnt`.
- `mtime` wraps from 2^64−1 to 0. The carry from LO into HI happens within the same tick.
- A software write to any `mtime` byte in the same cycle as a tick wins. The tick increment is discarded for the whole 64-bit value that cycle.
- `timer_interrupt` <= `irq_en` && (`mtime` >= `mtimecmp`), an unsigned 64-bit compare on current register values.

## Timing
- `rdata` and `hit`: combinational, valid in the same cycle as `addr` and `rd_en`. This matches the core's single-cycle MEM-WB writeback.
- Register writes take effect at the `clk` edge that ends the store cycle.
- A read in the same cycle as a write to the same register returns the old value.
- `timer_interrupt` lags register state by one cycle. It deasserts in the cycle after a `mtimecmp` write that moves the compare value above `mtime`.
- Synchronous reset mid-count restores all reset values at that edge. `timer_interrupt` is 0 in the following cycle.

## Structure
- Package `mtimer_pkg`:
  - offset constants `MTIMER_MTIME_LO` through `MTIMER_PRESCALE`
  - `acc_mode_t` enum for the five access modes
  - CTRL bit indices
  - reset constants
- Sub-module `mtimer_prescaler`, owning `pcnt`:
  - inputs `clk`, `rst`, `en`, `clr`, `prescale[15:0]`
  - output `tick`
- Lane merge and load extension are local functions in `mtimer`.

## Test plan
- Reset, then W-read every offset → MTIME 0/0, MTIMECMP FFFF_FFFF/FFFF_FFFF, CTRL 0, PRESCALE 0; `timer_interrupt`=0.
- PRESCALE=3, CTRL=1, wait 20 cycles → `mtime` = 5 (one tick per 4 cycles, counted from the CTRL write edge).
- Write MTIME_LO=FFFF_FFFF and MTIME_HI=0, with PRESCALE=0 and `en`=1 → next cycle reads LO 0, HI 1.
- Write MTIMECMP={0,10}, CTRL=3 → `timer_interrupt` rises exactly one cycle after `mtime` reaches 10. Writing MTIMECMP_HI=1 clears it one cycle later.
- Store B of 8'h80 to MTIMECMP_LO+1, then LB and LBU at the same address → FFFF_FF80 and 0000_0080. Other bytes are unchanged.
- SW to MTIME_LO at `addr` offset +2, and a read of offset 0x18 → write dropped and read 0. A same-cycle tick plus W-write of 7 to MTIME_LO → LO reads 7.

Source files
------------

// File: rtl/mtimer_pkg.sv
// mtimer_pkg: shared constants and types for the memory-mapped machine timer.
// Register word offsets (addr[4:2]), load/store access modes (funct3),
// CTRL bit positions and register reset values.
package mtimer_pkg;

    // Word offsets inside the 32-byte window
    localparam logic [2:0] MTIMER_MTIME_LO    = 3'd0;
    localparam logic [2:0] MTIMER_MTIME_HI    = 3'd1;
    localparam logic [2:0] MTIMER_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] MTIMER_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] MTIMER_CTRL        = 3'd4;
    localparam logic [2:0] MTIMER_PRESCALE    = 3'd5;

    // Load/store funct3 encodings
    typedef enum logic [2:0] {
        ACC_B  = 3'b000,
        ACC_H  = 3'b001,
        ACC_W  = 3'b010,
        ACC_BU = 3'b100,
        ACC_HU = 3'b101
    } acc_mode_t;

    // CTRL bit indices
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // Reset values
    localparam logic [63:0] MTIME_RST    = 64'h0;
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [1:0]  CTRL_RST     = 2'b00;
    localparam logic [15:0] PRESCALE_RST = 16'h0;

endpackage

// File: rtl/mtimer_prescaler.sv
// mtimer_prescaler: divides clk into mtime ticks, one tick every prescale+1 enabled cycles.
// Latency: tick is combinational from the current count; count updates at the clk edge.
// Backpressure: none; en=0 freezes the count, clr restarts it from 0.
// Ports: clk, rst (sync, active-high), en, clr, prescale[15:0] in; tick out.
module mtimer_prescaler (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] pcnt_q;
    logic [15:0] pcnt_d;

    // A tick is the cycle in which the count reaches the terminal value.
    // Lowering prescale below the live count lets the counter wrap through
    // 16'hFFFF before the next tick; software clears it by writing CTRL/PRESCALE.
    assign tick = en && (pcnt_q == prescale);

    always_comb begin
        pcnt_d = pcnt_q;
        if (clr) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = tick ? 16'h0 : pcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/mtimer.sv
// mtimer: memory-mapped 64-bit machine timer with compare and level interrupt.
// Latency: hit/rdata combinational; register writes at the store edge; timer_interrupt one cycle behind state.
// Backpressure: none; every access completes in its own cycle.
// Ports: clk, rst (sync, active-high); rd_en, wr_en, addr[31:0], mem_acc_mode[2:0], wdata[31:0] in;
//        hit, rdata[31:0], timer_interrupt out.
module mtimer
    import mtimer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [2:0]  mem_acc_mode,
    input  logic [31:0] wdata,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        timer_interrupt
);

    // Merge store data into an existing word; bytes outside the lanes keep their value.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] wd,
                                               input acc_mode_t   m,
                                               input logic [1:0]  a);
        logic [31:0] res;
        res = old_word;
        case (m)
            ACC_B:   res[{a, 3'b000} +: 8]      = wd[7:0];
            ACC_H:   res[{a[1], 4'b0000} +: 16] = wd[15:0];
            ACC_W:   res                        = wd;
            default: res                        = old_word;
        endcase
        return res;
    endfunction

    // Select the addressed lane and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input acc_mode_t   m,
                                                input logic [1:0]  a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        case (m)
            ACC_B:   res = {{24{b[7]}}, b};
            ACC_BU:  res = {24'h0, b};
            ACC_H:   res = {{16{h[15]}}, h};
            ACC_HU:  res = {16'h0, h};
            ACC_W:   res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    // Loads accept all five modes; stores only carry B/H/W funct3 codes.
    function automatic logic rd_legal(input acc_mode_t m, input logic [1:0] a);
        logic ok;
        case (m)
            ACC_B, ACC_BU: ok = 1'b1;
            ACC_H, ACC_HU: ok = !a[0];
            ACC_W:         ok = (a == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic wr_legal(input acc_mode_t m, input logic [1:0] a);
        logic ok;
        case (m)
            ACC_B:   ok = 1'b1;
            ACC_H:   ok = !a[0];
            ACC_W:   ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    acc_mode_t   mode;
    logic [2:0]  offset;
    logic [31:0] reg_word;
    logic [31:0] wr_word;
    logic        wr_ok;
    logic        tick;
    logic        pcnt_clr;

    logic [63:0] mtime_q,    mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [1:0]  ctrl_q,     ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic        irq_q;

    assign mode   = acc_mode_t'(mem_acc_mode);
    assign offset = addr[4:2];
    assign hit    = (addr[31:5] == BASE_ADDR[31:5]);
    assign wr_ok  = wr_en && hit && wr_legal(mode, addr[1:0]);

    // Raw register content at the addressed offset; reserved offsets read 0.
    always_comb begin
        reg_word = 32'h0;
        case (offset)
            MTIMER_MTIME_LO:    reg_word = mtime_q[31:0];
            MTIMER_MTIME_HI:    reg_word = mtime_q[63:32];
            MTIMER_MTIMECMP_LO: reg_word = mtimecmp_q[31:0];
            MTIMER_MTIMECMP_HI: reg_word = mtimecmp_q[63:32];
            MTIMER_CTRL:        reg_word = {30'h0, ctrl_q};
            MTIMER_PRESCALE:    reg_word = {16'h0, prescale_q};
            default:            reg_word = 32'h0;
        endcase
    end

    assign wr_word = lane_merge(reg_word, wdata, mode, addr[1:0]);
    assign rdata   = (rd_en && hit && rd_legal(mode, addr[1:0]))
                   ? load_extend(reg_word, mode, addr[1:0]) : 32'h0;

    always_comb begin
        // A store to either mtime half replaces the whole tick update, so the
        // untouched half is taken from mtime_q rather than the incremented value.
        mtime_d    = mtime_q + {63'h0, tick};
        mtimecmp_d = mtimecmp_q;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pcnt_clr   = 1'b0;
        if (wr_ok) begin
            case (offset)
                MTIMER_MTIME_LO:    mtime_d    = {mtime_q[63:32], wr_word};
                MTIMER_MTIME_HI:    mtime_d    = {wr_word, mtime_q[31:0]};
                MTIMER_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], wr_word};
                MTIMER_MTIMECMP_HI: mtimecmp_d = {wr_word, mtimecmp_q[31:0]};
                MTIMER_CTRL: begin
                    ctrl_d   = wr_word[1:0];
                    pcnt_clr = 1'b1;
                end
                MTIMER_PRESCALE: begin
                    prescale_d = wr_word[15:0];
                    pcnt_clr   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    mtimer_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl_q[CTRL_EN_BIT]),
        .clr      (pcnt_clr),
        .prescale (prescale_q),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q    <= MTIME_RST;
            mtimecmp_q <= MTIMECMP_RST;
            ctrl_q     <= CTRL_RST;
            prescale_q <= PRESCALE_RST;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            irq_q      <= ctrl_q[CTRL_IRQ_EN_BIT] && (mtime_q >= mtimecmp_q);
        end
    end

    assign timer_interrupt = irq_q;

endmodule

// File: tb/tb_mtimer.sv
// tb_mtimer: self-checking bench for mtimer; load results go through an
// expected-value queue, interrupt level is checked directly.
module tb_mtimer;
    import mtimer_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [2:0]  mem_acc_mode;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] rdata;
    logic        timer_interrupt;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    mtimer #(.BASE_ADDR(BASE)) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .wr_en           (wr_en),
        .addr            (addr),
        .mem_acc_mode    (mem_acc_mode),
        .wdata           (wdata),
        .hit             (hit),
        .rdata           (rdata),
        .timer_interrupt (timer_interrupt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic st(input logic [7:0] off, input logic [2:0] m, input logic [31:0] d);
        @(negedge clk);
        rd_en        = 1'b0;
        wr_en        = 1'b1;
        addr         = BASE + {24'h0, off};
        mem_acc_mode = m;
        wdata        = d;
    endtask

    // Push the expectation with the request, pop it when rdata settles.
    task automatic ld(input string tag, input logic [7:0] off, input logic [2:0] m,
                      input logic [31:0] exp);
        @(negedge clk);
        wr_en        = 1'b0;
        rd_en        = 1'b1;
        addr         = BASE + {24'h0, off};
        mem_acc_mode = m;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        chk(tag_q.pop_front(), rdata, exp_q.pop_front());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        addr = 32'h0; mem_acc_mode = ACC_W; wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_irq", {31'h0, timer_interrupt}, 32'h0);

        // Reset values
        ld("rst_mtime_lo", 8'h00, ACC_W, 32'h0);
        ld("rst_mtime_hi", 8'h04, ACC_W, 32'h0);
        ld("rst_cmp_lo",   8'h08, ACC_W, 32'hFFFF_FFFF);
        ld("rst_cmp_hi",   8'h0C, ACC_W, 32'hFFFF_FFFF);
        ld("rst_ctrl",     8'h10, ACC_W, 32'h0);
        ld("rst_prescale", 8'h14, ACC_W, 32'h0);
        chk("rst_hit", {31'h0, hit}, 32'h1);

        // Prescale 3: one tick per 4 cycles from the CTRL write edge
        st(8'h14, ACC_W, 32'h3);
        st(8'h10, ACC_W, 32'h1);
        repeat (20) idle();
        ld("presc_mtime_lo", 8'h00, ACC_W, 32'd5);
        ld("presc_mtime_hi", 8'h04, ACC_W, 32'd0);
        st(8'h10, ACC_W, 32'h0);

        // Carry from LO into HI within one tick
        st(8'h14, ACC_W, 32'h0);
        st(8'h10, ACC_W, 32'h1);
        st(8'h00, ACC_W, 32'hFFFF_FFFF);
        st(8'h04, ACC_W, 32'h0);
        idle();
        ld("carry_lo", 8'h00, ACC_W, 32'h0);
        ld("carry_hi", 8'h04, ACC_W, 32'h1);
        st(8'h10, ACC_W, 32'h0);

        // Interrupt at mtime == 10, cleared by moving the compare up
        st(8'h00, ACC_W, 32'h0);
        st(8'h04, ACC_W, 32'h0);
        st(8'h08, ACC_W, 32'd10);
        st(8'h0C, ACC_W, 32'h0);
        st(8'h10, ACC_W, 32'h3);
        repeat (10) idle();
        ld("irq_mtime10", 8'h00, ACC_W, 32'd10);
        chk("irq_not_yet", {31'h0, timer_interrupt}, 32'h0);
        idle();
        #1;
        chk("irq_rise", {31'h0, timer_interrupt}, 32'h1);
        st(8'h0C, ACC_W, 32'h1);
        idle();
        idle();
        #1;
        chk("irq_clear", {31'h0, timer_interrupt}, 32'h0);
        st(8'h10, ACC_W, 32'h0);

        // Byte and halfword lanes on MTIMECMP_LO (currently 10)
        st(8'h09, ACC_B, 32'hFFFF_FF80);
        ld("lb_neg",   8'h09, ACC_B,  32'hFFFF_FF80);
        ld("lbu",      8'h09, ACC_BU, 32'h0000_0080);
        ld("lw_after_sb", 8'h08, ACC_W, 32'h0000_800A);
        ld("lh_neg",   8'h08, ACC_H,  32'hFFFF_800A);
        st(8'h0A, ACC_H, 32'hABCD_1234);
        ld("lw_after_sh", 8'h08, ACC_W, 32'h1234_800A);
        ld("lhu_hi",   8'h0A, ACC_HU, 32'h0000_1234);
        ld("cmp_hi_kept", 8'h0C, ACC_W, 32'h1);

        // Misaligned and reserved accesses
        st(8'h00, ACC_W, 32'h55);
        st(8'h02, ACC_W, 32'hDEAD);
        ld("misal_w_dropped", 8'h00, ACC_W, 32'h55);
        ld("misal_w_read",    8'h02, ACC_W, 32'h0);
        ld("misal_h_read",    8'h01, ACC_H, 32'h0);
        st(8'h18, ACC_W, 32'hFFFF);
        ld("rsvd_18", 8'h18, ACC_W, 32'h0);
        ld("rsvd_1c", 8'h1C, ACC_W, 32'h0);
        ld("out_of_window", 8'h20, ACC_W, 32'h0);
        chk("out_hit", {31'h0, hit}, 32'h0);
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0; addr = BASE + 32'h8; mem_acc_mode = ACC_W;
        #1;
        chk("no_rd_en", rdata, 32'h0);

        // Same-cycle tick and store: the store wins
        st(8'h10, ACC_W, 32'h1);
        idle();
        idle();
        st(8'h00, ACC_W, 32'h7);
        ld("tick_vs_write_lo", 8'h00, ACC_W, 32'h7);
        ld("tick_vs_write_hi", 8'h04, ACC_W, 32'h0);

        // Reset while counting with the interrupt asserted
        st(8'h0C, ACC_W, 32'h0);
        st(8'h08, ACC_W, 32'h0);
        st(8'h10, ACC_W, 32'h3);
        idle();
        idle();
        #1;
        chk("irq_pre_rst", {31'h0, timer_interrupt}, 32'h1);
        @(negedge clk);
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("irq_post_rst", {31'h0, timer_interrupt}, 32'h0);
        ld("rst2_mtime_lo", 8'h00, ACC_W, 32'h0);
        ld("rst2_ctrl",     8'h10, ACC_W, 32'h0);
        ld("rst2_cmp_lo",   8'h08, ACC_W, 32'hFFFF_FFFF);
        ld("rst2_cmp_hi",   8'h0C, ACC_W, 32'hFFFF_FFFF);
        idle();
        #1;
        chk("irq_stays_low", {31'h0, timer_interrupt}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
